mult_sequencer: RTL and testbench

Control FSM plus accumulator for the shift-and-add multiplier in the multiplier peripheral. It sequences two external shiftregister instances:
- multiplicand register, width 2*W
- multiplier register, width W

Each cycle it adds the shifted multiplicand into a 2*W accumulator when the multiplier LSB is 1. It exposes a start/busy/done handshake to the peripheral's register interface.

---
 rtl/mult_sequencer_pkg.sv | 26 ++
 rtl/mult_sequencer_if.sv | 28 ++
 rtl/shiftregister.sv | 33 +++
 rtl/mult_sequencer.sv | 107 ++++++++++
 tb/tb_mult_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared constants for the shift-and-add multiplier: shift-register mode codes
// and sequencer state codes, decodable by the peripheral top and benches.
package mult_sequencer_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_PLOAD = 2'd3
  } shiftMode_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seqState_t;

  function automatic logic isBusyState(input seqState_t s);
    return (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Handshake and datapath bundle between the multiplier sequencer and its
// surroundings (register interface plus the two external shift registers).
interface mult_sequencer_if
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned W = 4
);

  logic             start;
  logic [2*W-1:0]   mcandIn;
  logic             mplierBit;
  shiftMode_t       mcandMode;
  shiftMode_t       mplierMode;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  modport master (
    output start, mcandIn, mplierBit,
    input  mcandMode, mplierMode, busy, done, product
  );

  modport slave (
    input  start, mcandIn, mplierBit,
    output mcandMode, mplierMode, busy, done, product
  );

endinterface

// File: rtl/shiftregister.sv
// Generic N-bit shift register with hold / parallel load / left / right modes,
// used externally for the multiplicand and multiplier operands.
module shiftregister
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  shiftMode_t   mode,
  input  logic         serialIn,
  input  logic [N-1:0] parallelIn,
  output logic [N-1:0] parallelOut
);

  logic [N-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_PLOAD: q <= parallelIn;
        MODE_LEFT:  q <= {q[N-2:0], serialIn};
        MODE_RIGHT: q <= {serialIn, q[N-1:1]};
        default:    q <= q;
      endcase
    end
  end

  assign parallelOut = q;

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM and 2W-bit accumulator for the shift-and-add multiplier; drives
// the mode inputs of the external multiplicand/multiplier shift registers.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             reset,
  mult_sequencer_if.slave  seq
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W) + 1;

  seqState_t       state;
  seqState_t       nextState;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;

  logic            busyNext;
  logic            doneNext;
  shiftMode_t      mcandModeNext;
  shiftMode_t      mplierModeNext;

  logic            busyQ;
  logic            doneQ;
  shiftMode_t      mcandModeQ;
  shiftMode_t      mplierModeQ;

  // State register; outputs are registered from the next-state decode so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      mcandModeQ  <= MODE_HOLD;
      mplierModeQ <= MODE_HOLD;
    end else begin
      state       <= nextState;
      busyQ       <= busyNext;
      doneQ       <= doneNext;
      mcandModeQ  <= mcandModeNext;
      mplierModeQ <= mplierModeNext;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (seq.start) nextState = ST_LOAD;
      ST_LOAD: nextState = ST_RUN;
      ST_RUN:  if (count == CW'(W - 1)) nextState = ST_DONE;
      ST_DONE: nextState = seq.start ? ST_LOAD : ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Output decode for the upcoming state.
  always_comb begin
    busyNext       = isBusyState(nextState);
    doneNext       = 1'b0;
    mcandModeNext  = MODE_HOLD;
    mplierModeNext = MODE_HOLD;
    case (nextState)
      ST_LOAD: begin
        mcandModeNext  = MODE_PLOAD;
        mplierModeNext = MODE_PLOAD;
      end
      ST_RUN: begin
        mcandModeNext  = MODE_LEFT;
        mplierModeNext = MODE_RIGHT;
      end
      ST_DONE: doneNext = 1'b1;
      default: ;
    endcase
  end

  // Accumulator and RUN-cycle counter; product holds outside LOAD/RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          acc   <= '0;
          count <= '0;
        end
        ST_RUN: begin
          count <= count + CW'(1);
          if (seq.mplierBit) acc <= acc + seq.mcandIn;
        end
        default: ;
      endcase
    end
  end

  assign seq.busy       = busyQ;
  assign seq.done       = doneQ;
  assign seq.mcandMode  = mcandModeQ;
  assign seq.mplierMode = mplierModeQ;
  assign seq.product    = acc;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench: sequencer plus two shift registers forming a 4x4 multiplier.
module tb_mult_sequencer;
  import mult_sequencer_pkg::*;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   opA = '0;
  logic [W-1:0]   opB = '0;
  logic [2*W-1:0] mcandQ;
  logic [W-1:0]   mplierQ;
  int             checks = 0;
  int             failures = 0;

  always #5 clk = ~clk;

  mult_sequencer_if #(.W(W)) bus ();

  shiftregister #(.N(2*W)) mcandReg (
    .clk(clk), .reset(reset), .mode(bus.mcandMode), .serialIn(1'b0),
    .parallelIn({{W{1'b0}}, opA}), .parallelOut(mcandQ)
  );

  shiftregister #(.N(W)) mplierReg (
    .clk(clk), .reset(reset), .mode(bus.mplierMode), .serialIn(1'b0),
    .parallelIn(opB), .parallelOut(mplierQ)
  );

  assign bus.mcandIn   = mcandQ;
  assign bus.mplierBit = mplierQ[0];

  mult_sequencer #(.W(W)) dut (
    .clk(clk), .reset(reset), .seq(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and waits for done; the sampling edge is edge 1.
  task automatic runMult(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] prod, output int edges, output int busyCycles);
    opA = a; opB = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    edges = 1; busyCycles = 0;
    while (bus.done !== 1'b1 && edges < 20) begin
      if (bus.busy === 1'b1) busyCycles++;
      tick();
      edges++;
    end
    prod = bus.product;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d want=0", bus.product); end
    checks++; if (bus.mcandMode !== MODE_HOLD || bus.mplierMode !== MODE_HOLD) begin
      failures++; $display("FAIL reset_modes got=%0d/%0d want=0/0", bus.mcandMode, bus.mplierMode); end
    checks++; if (mcandQ !== 8'd0 || mplierQ !== 4'd0) begin
      failures++; $display("FAIL reset_regs got=%0d/%0d want=0/0", mcandQ, mplierQ); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    opA = 4'd3; opB = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.mcandMode !== MODE_PLOAD || bus.mplierMode !== MODE_PLOAD) begin
      failures++; $display("FAIL load_cycle got busy=%b modes=%0d/%0d want busy=1 modes=3/3", bus.busy, bus.mcandMode, bus.mplierMode); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.mcandMode !== MODE_LEFT || bus.mplierMode !== MODE_RIGHT) begin
        failures++; $display("FAIL run_cycle%0d got busy=%b done=%b modes=%0d/%0d want busy=1 done=0 modes=1/2",
                             i, bus.busy, bus.done, bus.mcandMode, bus.mplierMode); end
    end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mcandMode !== MODE_HOLD || bus.mplierMode !== MODE_HOLD) begin
      failures++; $display("FAIL done_cycle got done=%b busy=%b modes=%0d/%0d want done=1 busy=0 modes=0/0",
                           bus.done, bus.busy, bus.mcandMode, bus.mplierMode); end
    checks++; if (bus.product !== 8'd15) begin failures++; $display("FAIL product_3x5 got=%0d want=15", bus.product); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.product !== 8'd15) begin
      failures++; $display("FAIL after_done got done=%b product=%0d want done=0 product=15", bus.done, bus.product); end
  endtask

  task automatic test_values();
    logic [W-1:0]   va [3] = '{4'd0, 4'd9, 4'd15};
    logic [W-1:0]   vb [3] = '{4'd9, 4'd0, 4'd15};
    logic [2*W-1:0] ve [3] = '{8'd0, 8'd0, 8'd225};
    logic [2*W-1:0] stepExp [4] = '{8'd9, 8'd9, 8'd45, 8'd45};
    logic [2*W-1:0] prod;
    int edges, busyCycles;
    for (int i = 0; i < 3; i++) begin
      runMult(va[i], vb[i], prod, edges, busyCycles);
      checks++; if (prod !== ve[i]) begin
        failures++; $display("FAIL product_%0dx%0d got=%0d want=%0d", va[i], vb[i], prod, ve[i]); end
      checks++; if (edges != 6 || busyCycles != 5) begin
        failures++; $display("FAIL latency_%0dx%0d got edges=%0d busy=%0d want edges=6 busy=5", va[i], vb[i], edges, busyCycles); end
      tick();
    end
    // 9x5: accumulator moves only on RUN edges where the multiplier LSB is 1.
    opA = 4'd9; opB = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.product !== 8'd0) begin failures++; $display("FAIL acc_cleared got=%0d want=0", bus.product); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.product !== stepExp[i]) begin
        failures++; $display("FAIL acc_step%0d got=%0d want=%0d", i, bus.product, stepExp[i]); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int doneSeen = 0;
    opA = 4'd6; opB = 4'd7; bus.start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) doneSeen++;
      tick();
    end
    checks++; if (doneSeen != 0 || bus.done !== 1'b1 || bus.product !== 8'd42) begin
      failures++; $display("FAIL held_start_6x7 got early=%0d done=%b product=%0d want early=0 done=1 product=42",
                           doneSeen, bus.done, bus.product); end
    opA = 4'd2; opB = 4'd3;
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.mcandMode !== MODE_PLOAD) begin
      failures++; $display("FAIL b2b_load got busy=%b done=%b mode=%0d want busy=1 done=0 mode=3", bus.busy, bus.done, bus.mcandMode); end
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.done !== 1'b1 || bus.product !== 8'd6) begin
      failures++; $display("FAIL b2b_2x3 got done=%b product=%0d want done=1 product=6", bus.done, bus.product); end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [2*W-1:0] prod;
    int edges, busyCycles;
    opA = 4'd11; opB = 4'd13; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    checks++; if (bus.product !== 8'd11) begin failures++; $display("FAIL partial_11x13 got=%0d want=11", bus.product); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'd0 ||
                  bus.mcandMode !== MODE_HOLD || bus.mplierMode !== MODE_HOLD) begin
      failures++; $display("FAIL midrun_reset got busy=%b done=%b product=%0d modes=%0d/%0d want 0/0/0/0/0",
                           bus.busy, bus.done, bus.product, bus.mcandMode, bus.mplierMode); end
    runMult(4'd11, 4'd13, prod, edges, busyCycles);
    checks++; if (prod !== 8'd143 || edges != 6) begin
      failures++; $display("FAIL rerun_11x13 got product=%0d edges=%0d want product=143 edges=6", prod, edges); end
    tick();
  endtask

  task automatic test_reset_start();
    logic [2*W-1:0] prod;
    int edges, busyCycles;
    reset = 1'b1; bus.start = 1'b1; opA = 4'd4; opB = 4'd4;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.mcandMode !== MODE_HOLD || bus.mplierMode !== MODE_HOLD) begin
      failures++; $display("FAIL reset_wins got busy=%b modes=%0d/%0d want busy=0 modes=0/0", bus.busy, bus.mcandMode, bus.mplierMode); end
    reset = 1'b0; bus.start = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset got busy=%b want=0", bus.busy); end
    runMult(4'd4, 4'd4, prod, edges, busyCycles);
    checks++; if (prod !== 8'd16) begin failures++; $display("FAIL product_4x4 got=%0d want=16", prod); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.product !== 8'd16 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL idle_hold%0d got product=%0d busy=%b want product=16 busy=0", i, bus.product, bus.busy); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_reset_midrun();
    test_reset_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
